if_id_queue: RTL and testbench
==============================

# if_id_queue

Instruction queue between the fetch stage and decode, replacing the single IF/ID latch. It buffers up to DEPTH fetched instructions with their incremented PC and fetch-error flag, so that an i-cache hit can complete while decode is stalled. It presents a first-word-fall-through head to decode, substitutes NOP (16'h0800) whenever empty, and discards all contents on a control-flow redirect.

## Interface
- DEPTH, 2: number of entries; power of two, ≥ 2.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset: synchronous, active-low; state clears on the rising edge of clk while rst = 0.
- in_valid  input  1  fetch presents a valid instruction this cycle.
- in_inst  input  16  fetched instruction.
- in_pc_inc  input  16  PC+2 of the fetched instruction.
- in_err  input  1  fetch/i-cache error flag for this instruction.
- in_ready  output  1  queue accepts an entry this cycle; fetch holds its PC when 0.
- out_valid  output  1  head entry is valid for decode.
- out_inst  output  16  head instruction; 16'h0800 when out_valid = 0.
- out_pc_inc  output  16  head PC+2; 16'h0000 when out_valid = 0.
- out_err  output  1  head error flag; 0 when out_valid = 0.
- out_ready  input  1  decode consumes the head this cycle (deasserted on decode stall).
- flush  input  1  redirect (branch misprediction or jump resolved in execute); empties the queue.
- count  output  log2(DEPTH)+1  number of occupied entries.

## Operation
- Storage: DEPTH entries of {inst[15:0], pc_inc[15:0], err}; read pointer rd_ptr and write pointer wr_ptr, each log2(DEPTH) bits, plus count register.
- enq = in_valid & in_ready & ~flush; deq = out_valid & out_ready & ~flush.
- in_ready = (count != DEPTH); combinational from count only. There is no bypass of a full queue, even when decode dequeues in the same cycle.
- out_valid = (count != 0); out_inst, out_pc_inc, and out_err are read combinationally from entry[rd_ptr] when valid, and are otherwise forced to NOP / 0 / 0.
- On enq: entry[wr_ptr] is written, and wr_ptr increments modulo DEPTH (natural wrap).
- On deq: rd_ptr increments modulo DEPTH.
- count: +1 on enq only; −1 on deq only; unchanged on both or neither.
- flush has priority over everything except reset: the next state is rd_ptr = wr_ptr = 0 and count = 0. Any same-cycle enq or deq is dropped, and entry data is not required to be cleared.
- in_err travels as data and does not block the queue. The decode/halt logic consumes out_err.
- Entry contents are never modified after being written; there is no partial update.

## Timing
- Reset (rst = 0 at a rising edge): count = 0, pointers = 0, so out_valid = 0, out_inst = 16'h0800, out_pc_inc = 0, out_err = 0, in_ready = 1. Reset overrides flush, enq, and deq.
- Latency: an entry enqueued at edge N appears at the head after edge N, provided the queue was empty. There is no same-cycle fetch→decode path.
- Empty with enq: out_valid stays 0 during that cycle, and decode sees NOP.
- Empty with out_ready = 1: no effect; count does not underflow.
- Full with in_valid = 1: the entry is not accepted, and fetch must hold in_inst and in_pc_inc stable until in_ready = 1.
- Full with deq: count becomes DEPTH−1 after the edge, and in_ready rises in the following cycle.
- Simultaneous enq and deq at count = k (0 < k < DEPTH): count stays k, and both pointers advance.
- flush with enq and deq in the same cycle: after the edge, count = 0 and out_inst = 16'h0800. The instruction presented that cycle is lost.
- Pointer wrap: after DEPTH enq/deq pairs, both pointers return to 0, and ordering is preserved.
- Reset asserted mid-operation: all entries are discarded at that edge, identical to power-on reset.

## Test plan
- Reset with rst = 0 for 2 cycles, then release -> count = 0, out_valid = 0, out_inst = 16'h0800, out_pc_inc = 0, in_ready = 1.
- Enqueue 16'hA123/pc 16'h0002, then 16'hB456/pc 16'h0004, with out_ready = 0 (DEPTH = 2) -> count = 2, in_ready = 0, head = 16'hA123; a third in_valid is ignored. Then set out_ready = 1 for 2 cycles -> heads are 16'hA123 then 16'hB456, then NOP with count = 0.
- Streaming: in_valid = out_ready = 1 for 10 cycles with incrementing instructions -> count holds at 1 after the first cycle, the output order matches the input, and the pointers wrap with no loss or duplication.
- Flush at count = 2 while in_valid = 1 and out_ready = 1 -> next cycle count = 0, out_inst = 16'h0800, and the flushed-cycle instruction never appears.
- Error propagation: enqueue with in_err = 1 behind one clean entry -> out_err = 0 for the first head, then 1 for the second; the queue keeps accepting entries.
- Reset mid-stream at count = 1 with in_valid = 1 -> count = 0 and out_valid = 0 after the edge, and the pending input is not stored.

Source files
------------

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: first-word-fall-through FIFO of
// {inst, pc_inc, err} that presents NOP while empty and empties on redirect.
module if_id_queue #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [15:0]                in_inst,
  input  logic [15:0]                in_pc_inc,
  input  logic                       in_err,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [15:0]                out_inst,
  output logic [15:0]                out_pc_inc,
  output logic                       out_err,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] NOP = 16'h0800;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on valid, and a flush cancels both sides.
  logic [15:0]   inst_mem   [DEPTH];
  logic [15:0]   pc_inc_mem [DEPTH];
  logic          err_mem    [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          enq;
  logic          deq;

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign enq       = in_valid & in_ready & ~flush;
  assign deq       = out_valid & out_ready & ~flush;

  always_comb begin
    out_inst   = NOP;
    out_pc_inc = 16'h0000;
    out_err    = 1'b0;
    if (out_valid) begin
      out_inst   = inst_mem[rd_ptr];
      out_pc_inc = pc_inc_mem[rd_ptr];
      out_err    = err_mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage is never cleared; the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (rst && enq) begin
      inst_mem[wr_ptr]   <= in_inst;
      pc_inc_mem[wr_ptr] <= in_pc_inc;
      err_mem[wr_ptr]    <= in_err;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed and random stimulus for if_id_queue, checked against a queue
// model of the expected contents.
module tb_if_id_queue;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [15:0]   in_inst;
  logic [15:0]   in_pc_inc;
  logic          in_err;
  logic          in_ready;
  logic          out_valid;
  logic [15:0]   out_inst;
  logic [15:0]   out_pc_inc;
  logic          out_err;
  logic          out_ready;
  logic          flush;
  logic [CW-1:0] count;

  int compared   = 0;
  int mismatched = 0;

  // Expected contents, head first: {inst, pc_inc, err}.
  logic [32:0] exp_q[$];

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_inst    (in_inst),
    .in_pc_inc  (in_pc_inc),
    .in_err     (in_err),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_inst   (out_inst),
    .out_pc_inc (out_pc_inc),
    .out_err    (out_err),
    .out_ready  (out_ready),
    .flush      (flush),
    .count      (count)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: applies one cycle of inputs, checks the head against the model,
  // then advances the model and the clock together.
  task automatic step(input logic r, input logic iv, input logic [15:0] inst,
                      input logic [15:0] pc, input logic err,
                      input logic ordy, input logic fl);
    int  sz;
    bit  m_enq;
    bit  m_deq;
    logic [32:0] head;
    rst       = r;
    in_valid  = iv;
    in_inst   = inst;
    in_pc_inc = pc;
    in_err    = err;
    out_ready = ordy;
    flush     = fl;
    #1;
    sz = exp_q.size();
    head = (sz != 0) ? exp_q[0] : {16'h0800, 16'h0000, 1'b0};
    chk("count",      32'(count),      32'(sz));
    chk("out_valid",  32'(out_valid),  32'(sz != 0));
    chk("in_ready",   32'(in_ready),   32'(sz != DEPTH));
    chk("out_inst",   32'(out_inst),   32'(head[32:17]));
    chk("out_pc_inc", 32'(out_pc_inc), 32'(head[16:1]));
    chk("out_err",    32'(out_err),    32'(head[0]));
    m_enq = iv && (sz != DEPTH) && !fl;
    m_deq = (sz != 0) && ordy && !fl;
    if (!r || fl) begin
      exp_q.delete();
    end else begin
      if (m_deq) void'(exp_q.pop_front());
      if (m_enq) exp_q.push_back({inst, pc, err});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc_inc = '0;
    in_err = 1'b0; out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();

    // Reset values
    idle();

    // Fill to full, third offer refused, then drain
    step(1'b1, 1'b1, 16'hA123, 16'h0002, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'hB456, 16'h0004, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'hC789, 16'h0006, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    idle();
    // Dequeue request while empty
    step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);

    // Streaming with pointer wrap
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b1, 16'h1000 + 16'(i), 16'h0100 + 16'(2 * i), 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    idle();

    // Flush at full with enq and deq requested
    step(1'b1, 1'b1, 16'h2001, 16'h0010, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h2002, 16'h0012, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'hDEAD, 16'h0014, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    idle();

    // Error flag travels as data
    step(1'b1, 1'b1, 16'hE001, 16'h0020, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'hE002, 16'h0022, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 16'hE003, 16'h0024, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);

    // Reset mid-stream at count = 1 with a pending input
    step(1'b1, 1'b1, 16'h3001, 16'h0030, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h3002, 16'h0032, 1'b0, 1'b1, 1'b0);
    idle();

    // Random traffic
    for (int i = 0; i < 60; i++)
      step(1'b1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
           16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
    step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    idle();

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
